fp32_mul_round_stage: RTL and testbench
=======================================

// Module: fp32_mul_round_stage
// PURPOSE
//  Downstream stage of the FP32 multiplier datapath. Takes the raw 48-bit mantissa product,
//  the pre-normalisation exponent, the sign and the special-case flags. Normalises and rounds
//  to nearest-even, resolves specials, and packs an IEEE-754 single.
//  Two-entry valid/ready pipeline; backpressure from the consumer stalls it losslessly.
// PARAMETERS
//  EXP_W   10  width of signed (two's complement) in_exp; must hold -254..+381
//  MANT_W  48  width of in_mant (24x24 product); fixed, other values unsupported
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       upstream holds a product
//  in_ready   out  1       stage accepts this cycle (transfer = in_valid & in_ready)
//  in_sign    in   1       result sign (sign_a ^ sign_b)
//  in_exp     in   EXP_W   signed exp_a+exp_b-127, before normalisation
//  in_mant    in   MANT_W  unsigned product of {hidden,frac} mantissas
//  in_is_nan  in   1       result is NaN (NaN operand or inf*0)
//  in_is_inf  in   1       result is infinity (and not NaN)
//  in_is_zero in   1       an operand was zero (and not NaN)
//  out_valid  out  1       out_z/out_flags valid
//  out_ready  in   1       consumer accepts (transfer = out_valid & out_ready)
//  out_z      out  32      packed IEEE-754 result
//  out_flags  out  5       {NV,OF,UF,NX,rsvd=0}; present only with FP_EXC_FLAGS_EN
// BEHAVIOUR
//  Reset (async, immediate): both stage valids, out_valid, out_z and out_flags go to 0;
//   in_ready=1 from the first edge after release. Reset mid-operation discards in-flight data.
//  Handshake: adv2 = ~v2 | out_ready; adv1 = ~v1 | adv2; in_ready = adv1 (combinational).
//   Latency 2 cycles from accept to out_valid when unstalled; throughput 1/cycle.
//   Outputs are held stable while out_valid & ~out_ready; order is preserved; no drop/dup.
//  S1 (normalise), registered on adv1:
//   in_mant[47]=1: keep [46:24], G=[23], S=|[22:0], e=in_exp+1.
//   else:          keep [45:23], G=[22], S=|[21:0], e=in_exp.
//   Specials and sign pass through.
//  S2 (round/pack), registered on adv2:
//   RNE: up = G & (S | keep[0]); m24 = {1,keep}+up; a carry into bit 24 gives frac=0, e+1.
//   Priority: nan -> 32'h7FC00000 (canonical qNaN; sign forced to 0).
//    inf -> {sign,8'hFF,23'h0}. zero -> {sign,31'h0}.
//    e>=255 -> {sign,8'hFF,0} (OF,NX). e<=0 -> flush to {sign,31'h0} (UF,NX).
//    else {sign,e[7:0],frac}; NX = G|S.
//  No subnormal inputs/outputs: subnormals are flushed to zero.
// CONFIGURATION
//  FP_EXC_FLAGS_EN defined: out_flags port exists. Flags are registered with out_z.
//   NV=nan; OF/UF/NX as in BEHAVIOUR; flags are 0 for inf and zero results.
//  Not defined: out_flags port and its logic are absent; out_z is bit-identical.
// STRUCTURE
//  Package fp32_pkg: EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000,
//   FLAG_NV/OF/UF/NX bit indices, and the normalised-record struct {sign,e,keep,G,S,specials}.
//  Sub-module fp32_rne_round: combinational S2 rounding/pack logic, instanced once.
// TESTING
//  1.5*1.5: in_exp=127, in_mant=48'h9000_0000_0000 -> out_z=32'h40100000, flags 0, latency 2.
//  Tie, even: in_exp=127, in_mant=48'h4000_0040_0000 -> 32'h3F800000, NX.
//   Tie, odd: in_mant=48'h4000_00C0_0000 -> 32'h3F800002, NX.
//  Overflow: in_exp=254, in_mant[47]=1 -> 32'h7F800000, OF|NX; in_exp=0, mant[46]=1 -> +0, UF|NX.
//  Specials: nan -> 7FC00000 NV; inf, sign=1 -> FF800000; zero, sign=1 -> 80000000.
//  Backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles -> in_ready drops after 2
//   accepts; all 4 emerge in order, with no duplicates.
//  Reset with both stages full -> out_valid=0 asynchronously; the first result after release
//   comes from a new input.

Source files
------------

// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared constants and normalised-record type for the FP32 multiplier round stage
package fp32_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_MAX    = 255;
    localparam int NORM_EXP_W = 12;
    localparam int FRAC_W     = 23;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_OF = 3;
    localparam int FLAG_UF = 2;
    localparam int FLAG_NX = 1;

    // e is two's complement; wide enough for the normalise and rounding increments
    typedef struct packed {
        logic                  sign;
        logic [NORM_EXP_W-1:0] e;
        logic [FRAC_W-1:0]     keep;
        logic                  g;
        logic                  s;
        logic                  is_nan;
        logic                  is_inf;
        logic                  is_zero;
    } norm_rec_t;

endpackage

// File: rtl/fp32_rne_round.sv
// rtl/fp32_rne_round.sv - combinational round-to-nearest-even and IEEE-754 pack; FP_EXC_FLAGS_EN adds flags
module fp32_rne_round
    import fp32_pkg::*;
(
    input  norm_rec_t   rec,
    output logic [31:0] z
`ifdef FP_EXC_FLAGS_EN
    ,
    output logic [4:0]  flags
`endif
);

    logic                  up;
    logic [FRAC_W:0]       m_rnd;
    logic [NORM_EXP_W-1:0] e_rnd;
    logic                  ovf;
    logic                  unf;

    always_comb begin
        up    = rec.g & (rec.s | rec.keep[0]);
        // a carry out of the fraction leaves frac all-zero and bumps the exponent
        m_rnd = {1'b0, rec.keep} + {{FRAC_W{1'b0}}, up};
        e_rnd = rec.e + {{(NORM_EXP_W-1){1'b0}}, m_rnd[FRAC_W]};
        ovf   = $signed(e_rnd) >= EXP_MAX;
        unf   = $signed(e_rnd) <= 0;

        z = {rec.sign, e_rnd[7:0], m_rnd[FRAC_W-1:0]};
        if (rec.is_nan) begin
            z = QNAN;
        end else if (rec.is_inf) begin
            z = {rec.sign, 8'hFF, 23'h0};
        end else if (rec.is_zero) begin
            z = {rec.sign, 31'h0};
        end else if (ovf) begin
            z = {rec.sign, 8'hFF, 23'h0};
        end else if (unf) begin
            z = {rec.sign, 31'h0};
        end
    end

`ifdef FP_EXC_FLAGS_EN
    always_comb begin
        flags = '0;
        if (rec.is_nan) begin
            flags[FLAG_NV] = 1'b1;
        end else if (!rec.is_inf && !rec.is_zero) begin
            flags[FLAG_NX] = 1'b1;
            if (ovf) begin
                flags[FLAG_OF] = 1'b1;
            end else if (unf) begin
                flags[FLAG_UF] = 1'b1;
            end else begin
                flags[FLAG_NX] = rec.g | rec.s;
            end
        end
    end
`endif

endmodule

// File: rtl/fp32_mul_round_stage.sv
// rtl/fp32_mul_round_stage.sv - two-stage normalise/round/pack pipeline for FP32 multiply; FP_EXC_FLAGS_EN adds out_flags
module fp32_mul_round_stage
    import fp32_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_is_nan,
    input  logic              in_is_inf,
    input  logic              in_is_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_z
`ifdef FP_EXC_FLAGS_EN
    ,
    output logic [4:0]        out_flags
`endif
);

    logic                  adv1;
    logic                  adv2;
    logic [NORM_EXP_W-1:0] exp_ext;
    norm_rec_t             norm;
    logic [31:0]           z_rnd;

    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    norm_rec_t             rec1_q, rec1_d;
    logic [31:0]           z_q, z_d;

    always_comb begin
        adv2 = ~v2_q | out_ready;
        adv1 = ~v1_q | adv2;

        exp_ext      = NORM_EXP_W'($signed(in_exp));
        norm         = '0;
        norm.sign    = in_sign;
        norm.is_nan  = in_is_nan;
        norm.is_inf  = in_is_inf;
        norm.is_zero = in_is_zero;
        norm.e       = exp_ext + {{(NORM_EXP_W-1){1'b0}}, in_mant[47]};
        if (in_mant[47]) begin
            norm.keep = in_mant[46:24];
            norm.g    = in_mant[23];
            norm.s    = |in_mant[22:0];
        end else begin
            norm.keep = in_mant[45:23];
            norm.g    = in_mant[22];
            norm.s    = |in_mant[21:0];
        end

        v1_d   = adv1 ? in_valid : v1_q;
        rec1_d = (adv1 && in_valid) ? norm : rec1_q;
        v2_d   = adv2 ? v1_q : v2_q;
        z_d    = (adv2 && v1_q) ? z_rnd : z_q;
    end

`ifdef FP_EXC_FLAGS_EN
    logic [4:0] flags_rnd;
    logic [4:0] flags_q, flags_d;

    fp32_rne_round u_round (
        .rec   (rec1_q),
        .z     (z_rnd),
        .flags (flags_rnd)
    );

    always_comb begin
        flags_d = (adv2 && v1_q) ? flags_rnd : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`else
    fp32_rne_round u_round (
        .rec (rec1_q),
        .z   (z_rnd)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            rec1_q <= '0;
            z_q    <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            rec1_q <= rec1_d;
            z_q    <= z_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_z     = z_q;

endmodule

// File: tb/tb_fp32_mul_round_stage.sv
// tb/tb_fp32_mul_round_stage.sv - randomized self-checking bench for fp32_mul_round_stage; FP_EXC_FLAGS_EN checks out_flags
module tb_fp32_mul_round_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
`ifdef FP_EXC_FLAGS_EN
    logic [4:0]  out_flags;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_in     = 0;
    int n_out    = 0;
    bit rand_ready = 0;
    bit prev_stall = 0;
    logic [31:0] prev_z;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    fp32_mul_round_stage #(.EXP_W(10), .MANT_W(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_is_zero (in_is_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z)
`ifdef FP_EXC_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic fail_event(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur as required", tag);
    endtask

    // reference: exact remainder vs. half-ulp comparison on the integer product
    function automatic logic [36:0] ref_model(input logic s, input logic signed [9:0] e,
                                              input logic [47:0] m, input logic [2:0] sp);
        int sh;
        int ex;
        logic [63:0] sig, rem, half;
        if (sp[2]) return {5'b10000, 32'h7FC00000};
        if (sp[1]) return {5'b00000, s, 8'hFF, 23'h0};
        if (sp[0]) return {5'b00000, s, 31'h0};
        sh   = m[47] ? 24 : 23;
        ex   = int'(e) + (m[47] ? 1 : 0);
        sig  = {16'b0, m} >> sh;
        rem  = {16'b0, m} & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
        if (sig[24]) begin
            sig = sig >> 1;
            ex  = ex + 1;
        end
        if (ex >= 255) return {5'b01010, s, 8'hFF, 23'h0};
        if (ex <= 0) return {5'b00110, s, 31'h0};
        return {3'b000, rem != 64'd0, 1'b0, s, ex[7:0], sig[22:0]};
    endfunction

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [2:0] sp);
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = e;
        in_mant    = m;
        in_is_nan  = sp[2];
        in_is_inf  = sp[1];
        in_is_zero = sp[0];
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [2:0] sp, input logic [36:0] expv);
        bit done = 0;
        drive(s, e, m, sp);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                n_in++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail_event("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [2:0] sp);
        send(s, e, m, sp, ref_model(s, e, m, sp));
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_item(output logic s, output logic [9:0] e, output logic [47:0] m, output logic [2:0] sp);
        logic [23:0] ma, mb;
        int r;
        ma = {1'b1, 23'($urandom)};
        mb = {1'b1, 23'($urandom)};
        m  = {24'b0, ma} * {24'b0, mb};
        if ($urandom_range(0, 3) == 0) m[21:0] = '0;
        s  = 1'($urandom);
        if ($urandom_range(0, 1) == 1) e = 10'($urandom_range(100, 160));
        else e = 10'(int'($urandom_range(0, 635)) - 254);
        r  = int'($urandom_range(0, 15));
        sp = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 : (r == 2) ? 3'b001 : 3'b000;
    endtask

    always @(negedge clk) begin
        logic [36:0] e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_z", out_z, prev_z);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_event("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("out_z", out_z, e[31:0]);
`ifdef FP_EXC_FLAGS_EN
                    check("out_flags", out_flags, e[36:32]);
`endif
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_z     = out_z;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        logic [2:0]  sp;
        int lat;
        int accepts;

        rst = 1'b1;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = '0;
        in_mant = '0;
        in_is_nan = 1'b0;
        in_is_inf = 1'b0;
        in_is_zero = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        send(1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, {5'b00000, 32'h40100000});
        lat = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, 2);
        @(posedge clk);
        #1;

        send(1'b0, 10'd127, 48'h4000_0040_0000, 3'b000, {5'b00010, 32'h3F800000});
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b000, {5'b00010, 32'h3F800002});
        send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 3'b000, {5'b00010, 32'h40000000});
        send(1'b0, 10'd254, 48'h8000_0000_0000, 3'b000, {5'b01010, 32'h7F800000});
        send(1'b0, 10'd0,   48'h4000_0000_0000, 3'b000, {5'b00110, 32'h00000000});
        send(1'b0, 10'd1,   48'h4000_0000_0000, 3'b000, {5'b00000, 32'h00800000});
        send(1'b1, 10'd127, 48'h9000_0000_0000, 3'b100, {5'b10000, 32'h7FC00000});
        send(1'b1, 10'd127, 48'h9000_0000_0000, 3'b010, {5'b00000, 32'hFF800000});
        send(1'b1, 10'd127, 48'h9000_0000_0000, 3'b001, {5'b00000, 32'h80000000});
        drain();

        out_ready = 1'b0;
        accepts = 0;
        rand_item(s, e, m, sp);
        drive(s, e, m, sp);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_model(s, e, m, sp));
                n_in++;
                accepts++;
                @(posedge clk);
                #1;
                rand_item(s, e, m, sp);
                drive(s, e, m, sp);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("bp_accepts", accepts, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        send_model(s, e, m, sp);
        rand_item(s, e, m, sp);
        send_model(s, e, m, sp);
        drain();

        out_ready = 1'b0;
        rand_item(s, e, m, sp);
        send_model(s, e, m, sp);
        rand_item(s, e, m, sp);
        send_model(s, e, m, sp);
        check("full_in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_z", out_z, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b000, {5'b00010, 32'h3F800002});
        drain();

        n_in = 0;
        n_out = 0;
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            rand_item(s, e, m, sp);
            send_model(s, e, m, sp);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        out_ready = 1'b1;
        drain();
        check("in_out_count", n_out, n_in);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
